// File: rtl/se_arbiter_pkg.sv
// Shared definitions for the search-engine arbiter: FSM encoding and bus widths.
package se_arbiter_pkg;

  localparam int MAC_W       = 48;
  localparam int HASH_W      = 10;
  localparam int RES_W       = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: one-hot winner among req, searching from (last + 1) mod NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] win
);

  // Walk the ring starting one past the last winner; the first request found wins.
  always_comb begin : pick
    logic [LW-1:0] idx;
    logic          found;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = LW'((int'(last) + off) % NREQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/se_arbiter.sv
// Shares one search engine among NREQ requesters: round-robin grant held for as
// long as the winner keeps its request up, a one-cycle gap after release, an
// engine-response watchdog, and lookup/timeout statistics.
module se_arbiter
  import se_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*MAC_W-1:0]  mac_i,
  input  logic [NREQ*HASH_W-1:0] hash_i,
  input  logic [NREQ-1:0]        source_i,
  output logic [NREQ-1:0]        ack_o,
  output logic [NREQ-1:0]        nak_o,
  output logic [RES_W-1:0]       result_o,
  output logic                   se_req,
  output logic                   se_source,
  output logic [MAC_W-1:0]       se_mac,
  output logic [HASH_W-1:0]      se_hash,
  input  logic                   se_ack,
  input  logic                   se_nak,
  input  logic [RES_W-1:0]       se_result,
  output logic [NREQ-1:0]        gnt_o,
  output logic [15:0]            lookup_cnt,
  output logic [7:0]             timeout_cnt
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Silent BUSY cycles are counted from zero, so the watchdog fires on the
  // TIMEOUT-th consecutive silent cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [NREQ-1:0]   gnt_nx, pick;
  logic [LW-1:0]     last_q, last_nx;
  logic [7:0]        wd_q, wd_nx;
  logic              busy, evt, to_hit;
  logic [MAC_W-1:0]  mac_arr  [NREQ];
  logic [HASH_W-1:0] hash_arr [NREQ];

  function automatic logic [LW-1:0] oh_idx(input logic [NREQ-1:0] oh);
    oh_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) oh_idx = LW'(i);
    end
  endfunction

  for (genvar k = 0; k < NREQ; k++) begin : g_split
    assign mac_arr[k]  = mac_i[k*MAC_W +: MAC_W];
    assign hash_arr[k] = hash_i[k*HASH_W +: HASH_W];
  end

  rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
    .req  (req_i),
    .last (last_q),
    .win  (pick)
  );

  assign busy     = (state == ST_BUSY);
  assign evt      = busy && (se_ack || se_nak);
  assign to_hit   = busy && !(se_ack || se_nak) && (wd_q == TO_LAST);
  assign result_o = se_result;

  // State, grant, last-winner, watchdog and statistics registers.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt_o       <= '0;
      last_q      <= LW'(NREQ - 1);
      wd_q        <= '0;
      lookup_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      state  <= state_nx;
      gnt_o  <= gnt_nx;
      last_q <= last_nx;
      wd_q   <= wd_nx;
      if (evt && lookup_cnt != 16'hFFFF) lookup_cnt <= lookup_cnt + 16'd1;
      if (to_hit && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

  // Next state: arbitrate in IDLE, hold while the winner's request stays up, one GAP cycle.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_o;
    last_nx  = last_q;
    wd_nx    = wd_q;
    unique case (state)
      ST_IDLE: begin
        if (|req_i) begin
          state_nx = ST_BUSY;
          gnt_nx   = pick;
          last_nx  = oh_idx(pick);
          wd_nx    = '0;
        end
      end
      ST_BUSY: begin
        if (evt || to_hit) wd_nx = '0;
        else               wd_nx = wd_q + 8'd1;
        if (!req_i[last_q]) begin
          state_nx = ST_GAP;
          gnt_nx   = '0;
        end
      end
      ST_GAP:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Engine-side mux and requester-side response steering; quiet outside BUSY.
  always_comb begin
    se_req    = 1'b0;
    se_source = 1'b0;
    se_mac    = '0;
    se_hash   = '0;
    ack_o     = '0;
    nak_o     = '0;
    if (busy) begin
      se_req        = req_i[last_q];
      se_source     = source_i[last_q];
      se_mac        = mac_arr[last_q];
      se_hash       = hash_arr[last_q];
      ack_o[last_q] = se_ack;
      nak_o[last_q] = se_nak || to_hit;
    end
  end

endmodule

// File: tb/tb_se_arbiter.sv
// Scoreboard bench for se_arbiter: the driver predicts grants and ack/nak pulses
// from round-robin and watchdog rules; a negedge monitor pops and compares.
module tb_se_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_i;
  logic [191:0] mac_i;
  logic [39:0]  hash_i;
  logic [3:0]   source_i;
  logic [3:0]   ack_o, nak_o;
  logic [15:0]  result_o;
  logic         se_req, se_source;
  logic [47:0]  se_mac;
  logic [9:0]   se_hash;
  logic         se_ack, se_nak;
  logic [15:0]  se_result;
  logic [3:0]   gnt_o;
  logic [15:0]  lookup_cnt;
  logic [7:0]   timeout_cnt;

  localparam int TO = 8;

  se_arbiter #(.NREQ(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .mac_i(mac_i), .hash_i(hash_i),
    .source_i(source_i), .ack_o(ack_o), .nak_o(nak_o), .result_o(result_o),
    .se_req(se_req), .se_source(se_source), .se_mac(se_mac), .se_hash(se_hash),
    .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result), .gnt_o(gnt_o),
    .lookup_cnt(lookup_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_gnt_q[$];
  logic [7:0] exp_resp_q[$];   // {ack vector, nak vector}
  int         exp_sel  = -1;   // requester expected on the engine bus, -1 when none
  int         cur_w, last_w, run, exp_lookups, exp_to;
  logic [3:0] pending;
  logic       rand_bus;
  logic [3:0] prev_gnt = '0;

  localparam logic [47:0] SRC_MAC = 48'h0011_2233_4455;
  localparam logic [47:0] DST_MAC = 48'hA0B1_C2D3_E4F5;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Round-robin rule: first pending requester after the last winner.
  function automatic int rr_model(input logic [3:0] p, input int last);
    int i;
    for (int off = 1; off <= 4; off++) begin
      i = (last + off) % 4;
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bus) begin
      for (int k = 0; k < 4; k++) begin
        mac_i[k*48 +: 48]  = 48'({$urandom(), $urandom()});
        hash_i[k*10 +: 10] = 10'($urandom());
      end
      source_i = 4'($urandom());
    end
    se_result = 16'($urandom());
  endtask

  // Expected consequences of one BUSY cycle with the given engine response.
  task automatic note_cycle(input logic a, input logic n);
    logic [3:0] one;
    one = 4'b1 << cur_w;
    if (a || n) begin
      exp_resp_q.push_back({a ? one : 4'b0, n ? one : 4'b0});
      if (exp_lookups < 16'hFFFF) exp_lookups++;
      run = 0;
    end else begin
      run++;
      if (run == TO) begin
        exp_resp_q.push_back({4'b0, one});
        if (exp_to < 8'hFF) exp_to++;
        run = 0;
      end
    end
  endtask

  task automatic busy_cycle(input logic a, input logic n);
    se_ack = a;
    se_nak = n;
    note_cycle(a, n);
    step();
    se_ack = 1'b0;
    se_nak = 1'b0;
  endtask

  // Called in an IDLE cycle with pending != 0; returns in BUSY cycle 1.
  task automatic begin_busy();
    cur_w  = rr_model(pending, last_w);
    last_w = cur_w;
    exp_gnt_q.push_back(cur_w);
    run = 0;
    step();
    exp_sel = cur_w;
  endtask

  // Drop the winner's request, pass the GAP cycle, return in the next IDLE cycle.
  task automatic end_busy(input logic [3:0] add_drop, input logic [3:0] add_gap);
    logic [3:0] one;
    one     = 4'b1 << cur_w;
    pending = (pending & ~one) | (add_drop & ~one);
    req_i   = pending;
    busy_cycle(1'b0, 1'b0);
    exp_sel = -1;
    pending = pending | add_gap;
    req_i   = pending;
    step();
    check("lookup_cnt", 64'(lookup_cnt), 64'(exp_lookups));
    check("timeout_cnt", 64'(timeout_cnt), 64'(exp_to));
  endtask

  task automatic drain();
    for (int g = 0; g < 8 && pending != 4'b0; g++) begin
      begin_busy();
      busy_cycle(1'b1, 1'b0);
      end_busy(4'b0, 4'b0);
    end
  endtask

  // Monitor: bus mux and quiet-state checks every cycle; pops on grant and response pulses.
  initial begin
    forever begin
      @(negedge clk);
      check("result_o", 64'(result_o), 64'(se_result));
      if (exp_sel >= 0) begin
        check("gnt_o", 64'(gnt_o), 64'(4'b1 << exp_sel));
        check("se_req", 64'(se_req), 64'(req_i[exp_sel]));
        check("se_mac", 64'(se_mac), 64'(mac_i[exp_sel*48 +: 48]));
        check("se_hash", 64'(se_hash), 64'(hash_i[exp_sel*10 +: 10]));
        check("se_source", 64'(se_source), 64'(source_i[exp_sel]));
      end else begin
        check("gnt_o_idle", 64'(gnt_o), 64'(0));
        check("se_bus_idle", {se_req, se_source, se_hash, se_mac}, 64'(0));
      end
      if (prev_gnt == 4'b0 && gnt_o != 4'b0) begin
        if (exp_gnt_q.size() == 0) check("grant_unexpected", 64'(gnt_o), 64'(0));
        else check("grant_order", 64'(gnt_o), 64'(4'b1 << exp_gnt_q.pop_front()));
      end
      prev_gnt = gnt_o;
      if ((ack_o | nak_o) != 4'b0) begin
        if (exp_resp_q.size() == 0) check("resp_unexpected", 64'({ack_o, nak_o}), 64'(0));
        else check("ack_nak", 64'({ack_o, nak_o}), 64'(exp_resp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [1:0] k;
    int         n_ev, d;
    rst = 1'b0; req_i = '0; mac_i = '0; hash_i = '0; source_i = '0;
    se_ack = 1'b0; se_nak = 1'b0; se_result = '0; rand_bus = 1'b1;
    pending = '0; last_w = 3; run = 0; exp_lookups = 0; exp_to = 0; cur_w = 0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    se_ack = 1'b1;
    req_i  = 4'b1111;
    #1;
    check("rst_gnt", 64'(gnt_o), 64'(0));
    check("rst_se_req", 64'(se_req), 64'(0));
    check("rst_ack", 64'({ack_o, nak_o}), 64'(0));
    check("rst_lookup", 64'(lookup_cnt), 64'(0));
    check("rst_timeout", 64'(timeout_cnt), 64'(0));
    se_ack = 1'b0;
    req_i  = '0;
    rst    = 1'b0;

    // All four requesting after reset; requester 0 re-raises in its GAP: 0,1,2,3,0.
    pending = 4'b1111; req_i = pending;
    begin_busy();
    busy_cycle(1'b1, 1'b0);
    end_busy(4'b0, 4'b0001);
    drain();

    // Single requester: acks after 3 and then 2 silent cycles.
    pending = 4'b0001; req_i = pending;
    begin_busy();
    repeat (3) busy_cycle(1'b0, 1'b0);
    busy_cycle(1'b1, 1'b0);
    repeat (2) busy_cycle(1'b0, 1'b0);
    busy_cycle(1'b1, 1'b0);
    end_busy(4'b0, 4'b0);
    check("single_lookup", 64'(lookup_cnt), 64'(7));

    // Stray ack and nak in IDLE: no forwarding, counters unchanged.
    se_ack = 1'b1; se_nak = 1'b1;
    step();
    se_ack = 1'b0; se_nak = 1'b0;
    step();
    check("stray_lookup", 64'(lookup_cnt), 64'(exp_lookups));

    // Requester 2 switches from source to destination MAC in its ack cycle.
    rand_bus = 1'b0;
    mac_i[2*48 +: 48] = SRC_MAC;
    pending = 4'b0100; req_i = pending;
    begin_busy();
    busy_cycle(1'b0, 1'b0);
    check("mac_src", 64'(se_mac), 64'(SRC_MAC));
    se_ack = 1'b1;
    mac_i[2*48 +: 48] = DST_MAC;
    note_cycle(1'b1, 1'b0);
    #1;
    check("mac_dst_same_cycle", 64'(se_mac), 64'(DST_MAC));
    step();
    se_ack = 1'b0;
    check("mac_dst_next", 64'(se_mac), 64'(DST_MAC));
    check("mac_switch_se_req", 64'(se_req), 64'(1));
    end_busy(4'b0, 4'b0);
    rand_bus = 1'b1;

    // Silent engine: timeout nak on BUSY cycle TO.
    pending = 4'b0010; req_i = pending;
    begin_busy();
    repeat (TO) busy_cycle(1'b0, 1'b0);
    check("timeout_once", 64'(timeout_cnt), 64'(1));
    busy_cycle(1'b1, 1'b0);
    end_busy(4'b0, 4'b0);

    // Randomized transactions with overlapping requests.
    for (int t = 0; t < 40; t++) begin
      if (pending == 4'b0) begin
        pending = 4'($urandom_range(1, 15));
        req_i   = pending;
      end
      begin_busy();
      n_ev = $urandom_range(1, 3);
      for (int e = 0; e < n_ev; e++) begin
        d = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3);
        repeat (d) busy_cycle(1'b0, 1'b0);
        k = 2'($urandom_range(1, 3));
        busy_cycle(k[0], k[1]);
      end
      end_busy(4'($urandom() & $urandom()), 4'($urandom() & $urandom()));
    end
    drain();

    // Reset in the middle of BUSY for requester 3.
    pending = 4'b1000; req_i = pending;
    begin_busy();
    busy_cycle(1'b0, 1'b0);
    exp_sel = -1;
    rst     = 1'b1;
    se_ack  = 1'b1;
    #1;
    check("midrst_se_req", 64'(se_req), 64'(0));
    check("midrst_gnt", 64'(gnt_o), 64'(0));
    check("midrst_ack", 64'({ack_o, nak_o}), 64'(0));
    check("midrst_lookup", 64'(lookup_cnt), 64'(0));
    last_w = 3; exp_lookups = 0; exp_to = 0; run = 0;
    step();
    step();
    se_ack = 1'b0; pending = '0; req_i = '0;
    rst = 1'b0;
    step();
    pending = 4'b1001; req_i = pending;
    begin_busy();
    busy_cycle(1'b1, 1'b0);
    end_busy(4'b0, 4'b0);
    drain();

    repeat (3) step();
    check("grants_left", 64'(exp_gnt_q.size()), 64'(0));
    check("responses_left", 64'(exp_resp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/se_arbiter.md
SE_ARBITER -- requirements
Module: se_arbiter

Interface
REQ-001 SHALL have parameters: NREQ, default 4, number of requesters; TIMEOUT, default 255, engine-response watchdog limit in cycles (8-bit).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have ports: req_i  in  NREQ  per-requester se_req.
REQ-005 SHALL have ports: mac_i  in  NREQ*48  per-requester se_mac, requester k at bits [48k+47:48k].
REQ-006 SHALL have ports: hash_i  in  NREQ*10  per-requester se_hash.
REQ-007 SHALL have ports: source_i  in  NREQ  per-requester se_source.
REQ-008 SHALL have ports: ack_o, nak_o  out  NREQ each  per-requester ack/nak pulses.
REQ-009 SHALL have ports: result_o  out  16  engine result broadcast to all requesters.
REQ-010 SHALL have ports: se_req, se_source  out  1; se_mac  out  48; se_hash  out  10; drive the shared search engine.
REQ-011 SHALL have ports: se_ack, se_nak  in  1; se_result  in  16; engine response.
REQ-012 SHALL have ports: gnt_o  out  NREQ  one-hot current grant; lookup_cnt  out  16; timeout_cnt  out  8.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, GAP; reset state IDLE.
REQ-014 IDLE: if any req_i set, SHALL register the round-robin winner into gnt_o, searching from (last winner + 1) mod NREQ, and enter BUSY next cycle.
REQ-015 IDLE with no req_i SHALL keep gnt_o = 0.
REQ-016 BUSY: se_req, se_mac, se_hash and se_source SHALL be a combinational mux of the granted requester's inputs, so mac/hash changes made by the requester on an ack cycle reach the engine with zero added latency.
REQ-017 Outside BUSY: se_req = 0, se_mac = 0, se_hash = 0, se_source = 0.
REQ-018 BUSY: ack_o/nak_o for the granted requester SHALL equal se_ack/se_nak combinationally; all other bits SHALL be 0.
REQ-019 result_o SHALL equal se_result at all times.
REQ-020 The grant SHALL be locked while the granted req_i stays high, covering back-to-back source-learn and destination-lookup transactions on one request.
REQ-021 When the granted req_i is sampled low in BUSY, SHALL enter GAP for exactly one cycle with se_req = 0, then return to IDLE.
REQ-022 lookup_cnt SHALL increment on every cycle with se_ack or se_nak in BUSY and saturate at 16'hFFFF.
REQ-023 An 8-bit watchdog SHALL clear on entry to BUSY and on each se_ack/se_nak, and increment on every other BUSY cycle.
REQ-024 When the watchdog reaches TIMEOUT, SHALL pulse nak_o of the granted requester for one cycle, increment timeout_cnt (saturating at 8'hFF), and clear the watchdog.
REQ-025 se_ack/se_nak arriving outside BUSY SHALL be ignored and SHALL NOT be counted.
REQ-026 If se_ack and se_nak are asserted together, both SHALL be forwarded; the event SHALL count once.
REQ-027 A request newly raised during GAP SHALL be arbitrated in the following IDLE cycle.
REQ-028 The requester just released SHALL have the lowest priority in that arbitration.

Reset
REQ-029 rst SHALL asynchronously force: state IDLE, gnt_o 0, last winner NREQ-1 (requester 0 has first priority), watchdog 0, lookup_cnt 0, timeout_cnt 0.
REQ-030 All engine-side and requester-side outputs SHALL read 0 during reset.
REQ-031 Reset asserted mid-BUSY SHALL drop se_req in the same cycle, with no ack/nak forwarded.

Structure
REQ-032 Shared package SHALL hold: FSM state encoding, MAC width 48, hash width 10, result width 16, default TIMEOUT.
REQ-033 Round-robin priority selection SHALL be one sub-module, rr_pick (inputs req, last; output one-hot winner).

Verification
REQ-034 Single requester: req_i=4'b0001, engine acks after 3 cycles, then again after 2 -> gnt_o=0001 throughout, two ack_o[0] pulses, lookup_cnt=2, GAP se_req=0 after req drops.
REQ-035 All four requesting after reset -> grants in order 0,1,2,3,0, one GAP cycle between each.
REQ-036 Mac switch on ack: requester 2 changes mac_i from source to destination MAC in the ack cycle -> se_mac shows the new value the next cycle, with no intervening se_req drop.
REQ-037 Engine silent, TIMEOUT=8 -> nak_o[granted] pulses at cycle 8 of BUSY, timeout_cnt=1.
REQ-038 Stray se_ack in IDLE -> no ack_o, lookup_cnt unchanged.
REQ-039 Reset asserted during BUSY with req_i=4'b1000 -> se_req=0 immediately; after release, requester 0 has first priority.
